// File: rtl/ring_osc_freq_counter.sv
// -----------------------------------------------------------------------------
// ring_osc_freq_counter
//
// Measures the frequency of the PVT-monitor ring oscillator. On a start request
// it enables the oscillator, lets it run up for SETTLE_CYCLES clocks, then counts
// synchronized rising edges of osc_in over a window of 2^WIN_LOG2 clocks.
// Oscillator frequency = count * f_clk / 2^WIN_LOG2.
//
// Parameters:
//   WIN_LOG2      : window length is 2^WIN_LOG2 clk cycles
//   CNT_W         : width of the accumulator and of the published count
//   SETTLE_CYCLES : oscillator run-up cycles before counting (>= 1)
//
// Ports:
//   clk      in   system clock, all state on the rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   measurement request, sampled in IDLE
//   osc_in   in   divided oscillator signal, asynchronous to clk
//   osc_ena  out  ring oscillator enable
//   busy     out  high from SETTLE through the last MEASURE cycle
//   count    out  last completed result, held until the next result
//   valid    out  one-cycle strobe, count/sat updated in the same cycle
//   sat      out  accumulator saturated during the published window
//
// Build option:
//   RO_FREQ_CONT_EN : continuous mode. If start is high at a window end the
//                     result is published and a new window begins on the next
//                     cycle without re-settling; osc_ena and busy stay high.
//                     Undefined: single-shot only.
// -----------------------------------------------------------------------------
module ring_osc_freq_counter #(
  parameter int WIN_LOG2      = 10,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             osc_in,
  output logic             osc_ena,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             sat
);

  // One timer serves both SETTLE and MEASURE, so it is sized for the longer.
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMR_W = (WIN_LOG2 > SET_W) ? WIN_LOG2 : SET_W;

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'((1 << WIN_LOG2) - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_acc;
  logic             r_sat_flag;
  logic             r_osc_ena;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic             r_sat;

  // Synchronizer (s1, s2) plus history flop s3 for edge detection.
  logic r_s1;
  logic r_s2;
  logic r_s3;

  logic             w_rise;
  logic             w_acc_full;
  logic [CNT_W-1:0] w_acc_next;
  logic             w_sat_next;

  // NOTE: sequential state is assigned with <= only, so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= osc_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;

  // Saturating increment. The flag records that a rise was dropped because
  // the accumulator was already all-ones.
  assign w_acc_full = &r_acc;
  assign w_acc_next = (w_rise && !w_acc_full) ? r_acc + CNT_W'(1) : r_acc;
  assign w_sat_next = r_sat_flag | (w_rise & w_acc_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_acc      <= '0;
      r_sat_flag <= 1'b0;
      r_osc_ena  <= 1'b0;
      r_busy     <= 1'b0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      // NOTE: the strobe defaults low every cycle and is overridden only at a
      // window end, which keeps it exactly one cycle wide.
      r_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_SETTLE;
            r_timer   <= '0;
            r_osc_ena <= 1'b1;
            r_busy    <= 1'b1;
          end
        end

        ST_SETTLE: begin
          // Rises are ignored while the oscillator runs up.
          if (r_timer == SETTLE_LAST) begin
            r_state    <= ST_MEASURE;
            r_timer    <= '0;
            r_acc      <= '0;
            r_sat_flag <= 1'b0;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        ST_MEASURE: begin
          r_acc      <= w_acc_next;
          r_sat_flag <= w_sat_next;
          if (r_timer == WIN_LAST) begin
            // A rise in the final window cycle is included in the result.
            r_count <= w_acc_next;
            r_sat   <= w_sat_next;
            r_valid <= 1'b1;
            r_timer <= '0;
`ifdef RO_FREQ_CONT_EN
            if (start) begin
              // Abutting window: the next cycle is the first of the new one.
              r_acc      <= '0;
              r_sat_flag <= 1'b0;
            end else begin
              r_state   <= ST_IDLE;
              r_osc_ena <= 1'b0;
              r_busy    <= 1'b0;
            end
`else
            r_state   <= ST_IDLE;
            r_osc_ena <= 1'b0;
            r_busy    <= 1'b0;
`endif
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_osc_ena <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign osc_ena = r_osc_ena;
  assign busy    = r_busy;
  assign count   = r_count;
  assign valid   = r_valid;
  assign sat     = r_sat;

endmodule
